bullet_controller: RTL and testbench
====================================

BULLET_CONTROLLER -- requirements
Module: bullet_controller

Interface
REQ-001 Parameter STEP_DIV, default 50000, clock cycles per one-pixel projectile move.
REQ-002 Parameter MAG_SIZE, default 4, magazine capacity (1..7).
REQ-003 Parameter SPAWN_Y, default 426, top row of a freshly fired projectile.
REQ-004 Parameter RELOAD_TICKS, default 1000, move-ticks before auto-reload (used only with AUTO_RELOAD_EN).
REQ-005 Port clk  input  1  system clock; all state on rising edge.
REQ-006 Port reset  input  1  asynchronous, active-low reset.
REQ-007 Port hcount  input  10  current pixel column.
REQ-008 Port vcount  input  10  current pixel row.
REQ-009 Port fire  input  1  raw trigger button, asynchronous to clk.
REQ-010 Port reload  input  1  manual reload request, level.
REQ-011 Port gun_x  input  10  left edge of the gun sprite, supplied by the gun block.
REQ-012 Port hit  input  1  one-cycle pulse from duck logic: projectile struck a target.
REQ-013 Port bullet_counter  output  3  rounds remaining, consumed by the gun block's ammo display.
REQ-014 Port shot_x  output  10  projectile left column.
REQ-015 Port shot_y  output  10  projectile top row.
REQ-016 Port shot_active  output  1  high while a projectile is in flight.
REQ-017 Port draw  output  1  current pixel lies on the projectile.
REQ-018 Port data  output  6  pixel colour when draw is high.

Function
REQ-019 Fire input shall pass a two-flop synchronizer; a shot request is a synchronized 0->1 edge.
REQ-020 FSM states IDLE, FLIGHT, EMPTY.
REQ-021 IDLE + shot request + bullet_counter>0: next cycle FLIGHT, bullet_counter-1, shot_x=gun_x+29 (captured), shot_y=SPAWN_Y, shot_active=1.
REQ-022 Shot requests in FLIGHT or EMPTY shall be discarded, not queued.
REQ-023 A free-running tick counter 0..STEP_DIV-1 shall pulse once per wrap; in FLIGHT each tick decrements shot_y by 1.
REQ-024 FLIGHT exits when hit is high or a tick occurs with shot_y==0; shot_active falls next cycle; hit takes priority when both coincide.
REQ-025 On FLIGHT exit: EMPTY if bullet_counter==0, else IDLE.
REQ-026 shot_y shall never wrap below 0; shot_x shall not track gun_x after launch.
REQ-027 reload high in IDLE or EMPTY sets bullet_counter=MAG_SIZE and state IDLE next cycle; ignored in FLIGHT.
REQ-028 hit outside FLIGHT shall be ignored.
REQ-029 draw/data registered, one-cycle latency: draw=1, data=6'b111111 when shot_active and shot_x<=hcount<=shot_x+3 and shot_y<=vcount<=shot_y+7; else draw=0, data=0.

Reset
REQ-030 While reset low: state IDLE, bullet_counter=MAG_SIZE, shot_x=0, shot_y=SPAWN_Y, shot_active=0, draw=0, data=0, tick and reload counters 0, synchronizer flops 0.
REQ-031 Reset mid-flight shall abort the projectile with no residual draw after release.

Configuration
REQ-032 Macro BULLET_AUTO_RELOAD_EN: defined -> in EMPTY, after RELOAD_TICKS ticks, bullet_counter=MAG_SIZE and state IDLE; manual reload still honoured and clears the count.
REQ-033 Undefined -> EMPTY persists until reload; reload counter and RELOAD_TICKS logic absent.

Structure
REQ-034 Shared package holds the FSM state enum, the 6-bit colour constants, and sprite dimension constants (width 4, height 8, barrel offset 29).
REQ-035 One sub-module, btn_sync_edge (two-flop synchronizer plus rising-edge pulse), instantiated for fire.

Verification
REQ-036 STEP_DIV=2, gun_x=100, pulse fire -> bullet_counter 4->3, shot_x=129, shot_y=426, shot_y 425 two cycles later.
REQ-037 Fire four times, each flight ending at shot_y 0 -> bullet_counter=0, state EMPTY, fifth fire no effect.
REQ-038 Hit pulse at shot_y=300 -> shot_active low next cycle, state IDLE, bullet_counter unchanged.
REQ-039 shot_x=129, shot_y=200, scan hcount=131 vcount=205 -> draw=1 and data=6'b111111 one cycle later; hcount=133 -> draw=0.
REQ-040 Without macro, EMPTY for 10000 cycles -> counter stays 0; reload pulse -> 4. With macro, RELOAD_TICKS=3 -> counter 4 after 3 ticks.
REQ-041 Reset asserted in FLIGHT at shot_y=250 -> shot_active=0, bullet_counter=4 immediately, draw=0 after release.

Source files
------------

// File: rtl/bullet_controller_pkg.sv
// Shared definitions for the bullet controller: FSM encodings, pixel colours
// and projectile sprite geometry.
package bullet_controller_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_FLIGHT = 2'd1;
    localparam state_t ST_EMPTY  = 2'd2;

    localparam logic [5:0] COLOR_SHOT = 6'b111111;
    localparam logic [5:0] COLOR_NONE = 6'b000000;

    // Sprite is SHOT_W x SHOT_H pixels; it leaves the gun BARREL_OFFSET px right of gun_x.
    localparam int SHOT_W        = 4;
    localparam int SHOT_H        = 8;
    localparam int BARREL_OFFSET = 29;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button, followed by a
// rising-edge detector that yields a one-cycle pulse in the clk domain.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/bullet_controller.sv
// Projectile controller: fires from the gun, climbs one row per move tick,
// tracks magazine ammo and renders the sprite with one cycle of latency.
// Define BULLET_AUTO_RELOAD_EN to refill an empty magazine after RELOAD_TICKS ticks.
module bullet_controller
    import bullet_controller_pkg::*;
#(
    parameter int STEP_DIV     = 50000,
    parameter int MAG_SIZE     = 4,
    parameter int SPAWN_Y      = 426,
    parameter int RELOAD_TICKS = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       fire,
    input  logic       reload,
    input  logic [9:0] gun_x,
    input  logic       hit,
    output logic [2:0] bullet_counter,
    output logic [9:0] shot_x,
    output logic [9:0] shot_y,
    output logic       shot_active,
    output logic       draw,
    output logic [5:0] data
);

    localparam int         TICK_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [2:0] MAG_FULL = 3'(MAG_SIZE);
    localparam logic [9:0] SPAWN_V  = 10'(SPAWN_Y);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [9:0]        shot_x_q, shot_x_d;
    logic [9:0]        shot_y_q, shot_y_d;
    logic              active_q, active_d;
    logic              draw_q, draw_d;
    logic [5:0]        data_q, data_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;
    logic              shot_req;
    logic              in_x, in_y;

`ifdef BULLET_AUTO_RELOAD_EN
    localparam int                RELOAD_W    = (RELOAD_TICKS > 1) ? $clog2(RELOAD_TICKS) : 1;
    localparam logic [RELOAD_W-1:0] RELOAD_LAST = RELOAD_W'(RELOAD_TICKS - 1);
    logic [RELOAD_W-1:0] reload_cnt_q, reload_cnt_d;
`endif

    btn_sync_edge u_fire_sync (
        .clk    (clk),
        .reset  (reset),
        .btn_in (fire),
        .rise   (shot_req)
    );

    assign tick = (tick_cnt_q == TICK_W'(STEP_DIV - 1));

    // NOTE: every _d starts from its _q value so no path through this block can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shot_x_d   = shot_x_q;
        shot_y_d   = shot_y_q;
        active_d   = active_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
`ifdef BULLET_AUTO_RELOAD_EN
        reload_cnt_d = '0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (reload) begin
                    cnt_d = MAG_FULL;
                end else if (shot_req && cnt_q != 3'd0) begin
                    state_d  = ST_FLIGHT;
                    cnt_d    = cnt_q - 3'd1;
                    shot_x_d = gun_x + 10'(BARREL_OFFSET);
                    shot_y_d = SPAWN_V;
                    active_d = 1'b1;
                end
            end
            ST_FLIGHT: begin
                // hit wins over a simultaneous move so the shot freezes where it struck.
                if (hit || (tick && shot_y_q == 10'd0)) begin
                    active_d = 1'b0;
                    state_d  = (cnt_q == 3'd0) ? ST_EMPTY : ST_IDLE;
                end else if (tick) begin
                    shot_y_d = shot_y_q - 10'd1;
                end
            end
            ST_EMPTY: begin
`ifdef BULLET_AUTO_RELOAD_EN
                reload_cnt_d = reload_cnt_q;
`endif
                if (reload) begin
                    cnt_d   = MAG_FULL;
                    state_d = ST_IDLE;
`ifdef BULLET_AUTO_RELOAD_EN
                    reload_cnt_d = '0;
                end else if (tick) begin
                    if (reload_cnt_q == RELOAD_LAST) begin
                        cnt_d        = MAG_FULL;
                        state_d      = ST_IDLE;
                        reload_cnt_d = '0;
                    end else begin
                        reload_cnt_d = reload_cnt_q + RELOAD_W'(1);
                    end
`endif
                end
            end
            default: begin
                state_d  = ST_IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    // Widened by one bit so the sprite's far edges never wrap near column/row 1023.
    always_comb begin
        in_x   = ({1'b0, hcount} >= {1'b0, shot_x_q}) &&
                 ({1'b0, hcount} <= {1'b0, shot_x_q} + 11'(SHOT_W - 1));
        in_y   = ({1'b0, vcount} >= {1'b0, shot_y_q}) &&
                 ({1'b0, vcount} <= {1'b0, shot_y_q} + 11'(SHOT_H - 1));
        draw_d = active_q && in_x && in_y;
        data_d = draw_d ? COLOR_SHOT : COLOR_NONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= MAG_FULL;
            shot_x_q   <= 10'd0;
            shot_y_q   <= SPAWN_V;
            active_q   <= 1'b0;
            draw_q     <= 1'b0;
            data_q     <= COLOR_NONE;
            tick_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shot_x_q   <= shot_x_d;
            shot_y_q   <= shot_y_d;
            active_q   <= active_d;
            draw_q     <= draw_d;
            data_q     <= data_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

`ifdef BULLET_AUTO_RELOAD_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reload_cnt_q <= '0;
        end else begin
            reload_cnt_q <= reload_cnt_d;
        end
    end
`endif

    assign bullet_counter = cnt_q;
    assign shot_x         = shot_x_q;
    assign shot_y         = shot_y_q;
    assign shot_active    = active_q;
    assign draw           = draw_q;
    assign data           = data_q;

endmodule

// File: tb/tb_bullet_controller.sv
// Scoreboard bench for bullet_controller: stimulus queues expected launches,
// landings and ammo changes; a negedge monitor pops them as the DUT shows them.
module tb_bullet_controller;

    localparam int STEP_DIV     = 2;
    localparam int MAG_SIZE     = 4;
    localparam int SPAWN_Y      = 426;
    localparam int RELOAD_TICKS = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] hcount, vcount, gun_x;
    logic       fire, reload, hit;
    logic [2:0] bullet_counter;
    logic [9:0] shot_x, shot_y;
    logic       shot_active, draw;
    logic [5:0] data;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
    } launch_t;

    launch_t    exp_launch[$];
    logic [9:0] exp_end_y[$];
    logic [2:0] exp_cnt[$];

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    logic [2:0] prev_cnt;
    logic       prev_active;

    bullet_controller #(
        .STEP_DIV     (STEP_DIV),
        .MAG_SIZE     (MAG_SIZE),
        .SPAWN_Y      (SPAWN_Y),
        .RELOAD_TICKS (RELOAD_TICKS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .hcount         (hcount),
        .vcount         (vcount),
        .fire           (fire),
        .reload         (reload),
        .gun_x          (gun_x),
        .hit            (hit),
        .bullet_counter (bullet_counter),
        .shot_x         (shot_x),
        .shot_y         (shot_y),
        .shot_active    (shot_active),
        .draw           (draw),
        .data           (data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s (no matching expectation queued)", name);
    endtask

    // Monitor: compares DUT events against the scoreboard queues.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bullet_counter !== prev_cnt) begin
                if (exp_cnt.size() == 0) report_fail("cnt_unexpected");
                else check("cnt_change", 32'(bullet_counter), 32'(exp_cnt.pop_front()));
            end
            if (shot_active && !prev_active) begin
                if (exp_launch.size() == 0) begin
                    report_fail("launch_unexpected");
                end else begin
                    launch_t l;
                    l = exp_launch.pop_front();
                    check("launch_x", 32'(shot_x), 32'(l.x));
                    check("launch_y", 32'(shot_y), 32'(l.y));
                end
            end
            if (!shot_active && prev_active) begin
                if (exp_end_y.size() == 0) report_fail("end_unexpected");
                else check("end_y", 32'(shot_y), 32'(exp_end_y.pop_front()));
            end
        end
        prev_cnt    = bullet_counter;
        prev_active = shot_active;
    end

    task automatic wait_active(input logic level, input int budget, input string name);
        int n = 0;
        while (shot_active !== level && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(shot_active), 32'(level));
    endtask

    task automatic wait_y(input logic [9:0] y, input int budget, input string name);
        int n = 0;
        while (!(shot_active === 1'b1 && shot_y === y) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(shot_y), 32'(y));
    endtask

    // Hold fire until the launch is seen, then release it.
    task automatic fire_and_launch(input logic [9:0] gx, input logic [2:0] cnt_after, input string name);
        launch_t l;
        gun_x = gx;
        l.x = gx + 10'd29;
        l.y = 10'(SPAWN_Y);
        exp_launch.push_back(l);
        exp_cnt.push_back(cnt_after);
        @(negedge clk);
        fire = 1'b1;
        wait_active(1'b1, 20, name);
        fire = 1'b0;
    endtask

    initial begin
        reset  = 1'b0;
        hcount = '0;
        vcount = '0;
        gun_x  = 10'd100;
        fire   = 1'b0;
        reload = 1'b0;
        hit    = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_counter", 32'(bullet_counter), 32'd4);
        check("rst_shot_x",  32'(shot_x), 32'd0);
        check("rst_shot_y",  32'(shot_y), 32'd426);
        check("rst_active",  32'(shot_active), 32'd0);
        check("rst_draw",    32'(draw), 32'd0);
        check("rst_data",    32'(data), 32'd0);

        reset = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Flight 1: launch, first move, no gun tracking, ignored fire/reload, hit at 300.
        fire_and_launch(10'd100, 3'd3, "launch1");
        repeat (2) @(negedge clk);
        check("first_move_y", 32'(shot_y), 32'd425);
        gun_x  = 10'd300;
        reload = 1'b1;
        repeat (2) @(negedge clk);
        reload = 1'b0;
        repeat (4) @(negedge clk);
        fire = 1'b1;
        repeat (4) @(negedge clk);
        fire = 1'b0;
        wait_y(10'd300, 1000, "reach_300");
        check("no_gun_track", 32'(shot_x), 32'd129);
        exp_end_y.push_back(10'd300);
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
        check("hit_ends_flight", 32'(shot_active), 32'd0);
        check("hit_keeps_count", 32'(bullet_counter), 32'd3);

        // Flight 2: render scan around shot (129,200), then land at row 0.
        fire_and_launch(10'd100, 3'd2, "launch2");
        wait_y(10'd200, 1000, "reach_200");
        hcount = 10'd131; vcount = 10'd205;
        @(negedge clk);
        check("draw_inside", 32'(draw), 32'd1);
        check("data_inside", 32'(data), 32'd63);
        hcount = 10'd133;
        @(negedge clk);
        check("draw_right_out", 32'(draw), 32'd0);
        check("data_right_out", 32'(data), 32'd0);
        hcount = 10'd132;
        @(negedge clk);
        check("draw_right_edge", 32'(draw), 32'd1);
        hcount = 10'd128;
        @(negedge clk);
        check("draw_left_out", 32'(draw), 32'd0);
        hcount = '0; vcount = '0;
        exp_end_y.push_back(10'd0);
        wait_active(1'b0, 1200, "land2");

        // Flights 3 and 4 empty the magazine.
        fire_and_launch(10'd50, 3'd1, "launch3");
        exp_end_y.push_back(10'd0);
        wait_active(1'b0, 1200, "land3");
        fire_and_launch(10'd50, 3'd0, "launch4");
        exp_end_y.push_back(10'd0);
        wait_active(1'b0, 1200, "land4");

        // Empty magazine: fifth fire and a stray hit do nothing.
        @(negedge clk);
        fire = 1'b1;
        repeat (6) @(negedge clk);
        fire = 1'b0;
        hit  = 1'b1;
        @(negedge clk);
        hit  = 1'b0;
        repeat (6) @(negedge clk);
        check("empty_no_fire", 32'(shot_active), 32'd0);
        check("empty_count",   32'(bullet_counter), 32'd0);

`ifdef BULLET_AUTO_RELOAD_EN
        exp_cnt.push_back(3'd4);
        begin
            int n = 0;
            while (bullet_counter !== 3'd4 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("auto_reload", 32'(bullet_counter), 32'd4);
`else
        repeat (10000) @(negedge clk);
        check("empty_persists", 32'(bullet_counter), 32'd0);
        exp_cnt.push_back(3'd4);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        @(negedge clk);
        check("manual_reload", 32'(bullet_counter), 32'd4);
`endif

        // Flight 5: reset mid-flight at row 250.
        fire_and_launch(10'd100, 3'd3, "launch5");
        wait_y(10'd250, 1000, "reach_250");
        hcount = 10'd130; vcount = 10'd252;
        exp_cnt.push_back(3'd4);
        exp_end_y.push_back(10'd426);
        reset = 1'b0;
        #1;
        check("rst_flight_active",  32'(shot_active), 32'd0);
        check("rst_flight_counter", 32'(bullet_counter), 32'd4);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_draw", 32'(draw), 32'd0);
        end

        repeat (4) @(negedge clk);
        check("launch_q_drained", 32'(exp_launch.size()), 32'd0);
        check("end_q_drained",    32'(exp_end_y.size()), 32'd0);
        check("cnt_q_drained",    32'(exp_cnt.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
